// File: rtl/fetch_pkg.sv
// Purpose: shared types and constants for the instruction-fetch stage.
// Contents: packet payload held in the output queue, fetch state encoding,
//           default address/instruction widths and instruction size in bytes.
package fetch_pkg;

    localparam int unsigned FETCH_XLEN   = 64;
    localparam int unsigned FETCH_INST_W = 32;
    localparam int unsigned INST_BYTES   = 4;

    typedef enum logic [1:0] {
        FS_RUN,
        FS_FAULT,
        FS_HALT
    } fetch_state_e;

    // npc is not stored; it is derived from pc at the output
    typedef struct packed {
        logic [FETCH_XLEN-1:0]   pc;
        logic [FETCH_INST_W-1:0] inst;
        logic                    exc;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_if.sv
// Purpose: fetch -> decode packet channel with valid/ready handshake.
// Signals: valid, ready, pc, npc, inst, exc.
//   master (fetch):  drives valid/pc/npc/inst/exc, samples ready
//   slave  (decode): samples packet, drives ready
interface fetch_if #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned INST_W = 32
);
    logic              valid;
    logic              ready;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   npc;
    logic [INST_W-1:0] inst;
    logic              exc;

    modport master (output valid, pc, npc, inst, exc, input ready);
    modport slave  (input valid, pc, npc, inst, exc, output ready);
endinterface

// File: rtl/fetch_queue.sv
// Purpose: small synchronous FIFO of fetch packets with flush.
// Ports:
//   clk, rst_      clock, synchronous active-low reset
//   flush          drop all entries (wins over push)
//   push, push_pkt enqueue one packet
//   pop            dequeue head (caller guarantees non-empty)
//   head           packet at the head of the queue
//   count          number of valid entries
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 3,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             flush,
    input  logic             push,
    input  fetch_pkt_t       push_pkt,
    input  logic             pop,
    output fetch_pkt_t       head,
    output logic [CNT_W-1:0] count
);

    fetch_pkt_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (!rst_ || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; count qualifies every entry
    always_ff @(posedge clk) begin
        if (rst_ && !flush && push) mem[wr_ptr] <= push_pkt;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Purpose: RV64 instruction-fetch stage. Owns the PC, reads a 1-cycle
//          synchronous imem and queues {pc, inst, exc} packets for decode.
// Ports:
//   clk, rst_            clock, synchronous active-low reset
//   o_imem_addr          imem word address (pc[IMEM_ADDR_WIDTH+1:2])
//   o_imem_en            read issued this cycle
//   i_imem_rdata         read data, valid the cycle after o_imem_en
//   i_redirect_valid/pc  branch/jump/trap redirect; flushes and restarts fetch
//   dec                  packet channel to decode (valid/ready, pc, npc, inst, exc)
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN            = FETCH_XLEN,
    parameter int unsigned     IMEM_DEPTH      = 2048,
    parameter int unsigned     IMEM_ADDR_WIDTH = $clog2(IMEM_DEPTH),
    parameter int unsigned     IMEM_DATA_WIDTH = FETCH_INST_W,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int unsigned     QDEPTH          = 3
) (
    input  logic                       clk,
    input  logic                       rst_,
    output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
    output logic                       o_imem_en,
    input  logic [IMEM_DATA_WIDTH-1:0] i_imem_rdata,
    input  logic                       i_redirect_valid,
    input  logic [XLEN-1:0]            i_redirect_pc,
    fetch_if.master                    dec
);

    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

    fetch_state_e     state;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  tag;
    logic [XLEN-1:0]  fault_pc;
    logic             inflight;

    logic [CNT_W-1:0] q_count;
    fetch_pkt_t       q_head;
    fetch_pkt_t       push_pkt;
    fetch_pkt_t       out_pkt;
    logic             q_valid;
    logic             issue;
    logic             push;
    logic             pop;
    logic             out_valid;

    // Issue/enqueue/dequeue decisions and output packet selection
    always_comb begin
        q_valid  = (q_count != '0);
        // Credit check: queued plus in-flight must leave room for one more
        issue    = rst_ && (state == FS_RUN) && !i_redirect_valid &&
                   ((32'(q_count) + 32'(inflight)) < QDEPTH);
        // A redirect squashes the read whose data arrives this cycle
        push     = inflight && !i_redirect_valid;
        pop      = (state == FS_RUN) && q_valid && dec.ready;
        push_pkt = '{pc: tag, inst: i_imem_rdata, exc: 1'b0};

        out_valid = (state == FS_FAULT) || ((state == FS_RUN) && q_valid);
        out_pkt   = q_head;
        if (state == FS_FAULT) out_pkt = '{pc: fault_pc, inst: '0, exc: 1'b1};
        if (!out_valid)        out_pkt = '0;
    end

    // PC, in-flight tracking and RUN/FAULT/HALT control
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state    <= FS_RUN;
            pc       <= RESET_PC;
            tag      <= '0;
            fault_pc <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                tag <= pc;
                pc  <= pc + XLEN'(INST_BYTES);
            end
            if (i_redirect_valid) begin
                if (i_redirect_pc[1:0] == 2'b00) begin
                    pc    <= i_redirect_pc;
                    state <= FS_RUN;
                end else begin
                    fault_pc <= i_redirect_pc;
                    state    <= FS_FAULT;
                end
            end else if ((state == FS_FAULT) && dec.ready) begin
                state <= FS_HALT;
            end
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk      (clk),
        .rst_     (rst_),
        .flush    (i_redirect_valid),
        .push     (push),
        .push_pkt (push_pkt),
        .pop      (pop),
        .head     (q_head),
        .count    (q_count)
    );

    assign o_imem_en   = issue;
    assign o_imem_addr = pc[IMEM_ADDR_WIDTH+1:2];

    assign dec.valid = out_valid;
    assign dec.pc    = out_pkt.pc;
    assign dec.npc   = out_valid ? (out_pkt.pc + XLEN'(INST_BYTES)) : '0;
    assign dec.inst  = out_pkt.inst;
    assign dec.exc   = out_pkt.exc;

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose: directed self-checking bench for fetch_unit.
// Drives inputs on the falling edge, samples 1 time unit later; a behavioural
// imem returns word_address + 0x100 one cycle after each read.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk            = 1'b0;
    logic        rst_           = 1'b0;
    logic [10:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata     = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc    = '0;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] acc[$];

    fetch_if #(.XLEN(64), .INST_W(32)) dec ();

    fetch_unit dut (
        .clk              (clk),
        .rst_             (rst_),
        .o_imem_addr      (imem_addr),
        .o_imem_en        (imem_en),
        .i_imem_rdata     (imem_rdata),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .dec              (dec)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= 32'(imem_addr) + 32'h100;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: apply inputs, settle, check packet invariants, log transfers
    task automatic step(input logic r, input logic rdy, input logic rv, input logic [63:0] rpc);
        logic [63:0] p;
        logic [31:0] exp_inst;
        @(negedge clk);
        rst_           = r;
        dec.ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        if (dec.valid) begin
            p        = dec.pc;
            exp_inst = dec.exc ? 32'h0 : (32'(p[12:2]) + 32'h100);
            check("npc", dec.npc, p + 64'd4);
            check("inst", 64'(dec.inst), 64'(exp_inst));
            if (dec.ready) acc.push_back(p);
        end
    endtask

    initial begin
        dec.ready = 1'b0;

        // Reset state
        step(1'b0, 1'b1, 1'b0, 64'h0);
        check("rst_valid", 64'(dec.valid), 64'd0);
        check("rst_en", 64'(imem_en), 64'd0);
        check("rst_pc", dec.pc, 64'd0);
        check("rst_npc", dec.npc, 64'd0);
        check("rst_inst", 64'(dec.inst), 64'd0);
        check("rst_exc", 64'(dec.exc), 64'd0);
        step(1'b0, 1'b1, 1'b0, 64'h0);

        // Streaming start: issue 0,1,2..., first packet two cycles after release
        step(1'b1, 1'b1, 1'b0, 64'h0);
        check("c0_en", 64'(imem_en), 64'd1);
        check("c0_addr", 64'(imem_addr), 64'd0);
        check("c0_valid", 64'(dec.valid), 64'd0);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        check("c1_en", 64'(imem_en), 64'd1);
        check("c1_addr", 64'(imem_addr), 64'd1);
        check("c1_valid", 64'(dec.valid), 64'd0);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        check("c2_valid", 64'(dec.valid), 64'd1);
        check("c2_pc", dec.pc, 64'h0);
        check("c2_inst", 64'(dec.inst), 64'h100);
        check("c2_addr", 64'(imem_addr), 64'd2);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        check("c3_pc", dec.pc, 64'h4);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        check("c4_pc", dec.pc, 64'h8);

        // Backpressure: one more issue then stall, head held at 0xc
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 64'h0);
            check("bp_en", 64'(imem_en), (i == 0) ? 64'd1 : 64'd0);
            check("bp_valid", 64'(dec.valid), 64'd1);
            check("bp_pc", dec.pc, 64'hc);
        end
        repeat (6) step(1'b1, 1'b1, 1'b0, 64'h0);
        check("bp_count", 64'(acc.size()), 64'd9);
        for (int i = 0; i < acc.size(); i++) check("bp_order", acc[i], 64'(4 * i));

        // Redirect with two queued packets and a read in flight
        step(1'b1, 1'b0, 1'b0, 64'h0);
        step(1'b1, 1'b0, 1'b1, 64'h40);
        check("rd_en", 64'(imem_en), 64'd0);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        check("rd_valid0", 64'(dec.valid), 64'd0);
        check("rd_en1", 64'(imem_en), 64'd1);
        check("rd_addr", 64'(imem_addr), 64'h10);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        check("rd_valid1", 64'(dec.valid), 64'd0);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        check("rd_pc0", dec.pc, 64'h40);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        check("rd_count", 64'(acc.size()), 64'd11);
        check("rd_acc0", acc[9], 64'h40);
        check("rd_acc1", acc[10], 64'h44);

        // Redirect in the same cycle as a transfer
        step(1'b1, 1'b1, 1'b1, 64'h100);
        check("rt_pc", dec.pc, 64'h48);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        check("rt_valid", 64'(dec.valid), 64'd0);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        check("rt_pc1", dec.pc, 64'h100);
        check("rt_count", 64'(acc.size()), 64'd13);
        check("rt_acc0", acc[11], 64'h48);
        check("rt_acc1", acc[12], 64'h100);

        // Misaligned redirect -> exception packet, then halt
        step(1'b1, 1'b0, 1'b1, 64'h42);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        check("ex_valid", 64'(dec.valid), 64'd1);
        check("ex_exc", 64'(dec.exc), 64'd1);
        check("ex_pc", dec.pc, 64'h42);
        check("ex_npc", dec.npc, 64'h46);
        check("ex_inst", 64'(dec.inst), 64'd0);
        check("ex_en", 64'(imem_en), 64'd0);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        check("ex_hold", dec.pc, 64'h42);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 64'h0);
            check("halt_valid", 64'(dec.valid), 64'd0);
            check("halt_en", 64'(imem_en), 64'd0);
        end
        step(1'b1, 1'b1, 1'b1, 64'h80);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        check("rs_en", 64'(imem_en), 64'd1);
        check("rs_addr", 64'(imem_addr), 64'h20);
        check("rs_valid", 64'(dec.valid), 64'd0);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        check("rs_pc", dec.pc, 64'h80);
        check("rs_exc", 64'(dec.exc), 64'd0);

        // Mid-stream reset under backpressure
        step(1'b1, 1'b0, 1'b0, 64'h0);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        step(1'b0, 1'b0, 1'b0, 64'h0);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        check("mr_valid", 64'(dec.valid), 64'd0);
        check("mr_en", 64'(imem_en), 64'd1);
        check("mr_addr", 64'(imem_addr), 64'd0);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        check("mr_valid1", 64'(dec.valid), 64'd0);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        check("mr_pc0", dec.pc, 64'h0);
        check("mr_inst0", 64'(dec.inst), 64'h100);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        check("mr_pc1", dec.pc, 64'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
